// File: rtl/cg_addr_sequencer.sv
// Address sequencer for an iterative vector solver: per-channel read/write
// address generation, matrix-A streaming address, and iteration control.
module cg_addr_sequencer #(
   parameter int unsigned NUM_UNITS = 8,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned MAX_ITER  = 3,
   parameter int unsigned DONE_HOLD = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        total,
   input  logic                     a_stream_en,
   input  logic [NUM_CH-1:0]        rd_adv,
   input  logic [NUM_CH-1:0]        wr_req,
   input  logic                     phase_done,
   input  logic                     finish_all,
   output logic [ADDR_W-1:0]        a_rd_addr,
   output logic [NUM_CH*ADDR_W-1:0] rd_addr,
   output logic [NUM_CH*ADDR_W-1:0] wr_addr,
   output logic [NUM_CH-1:0]        wr_we,
   output logic [NUM_CH-1:0]        rd_wrap,
   output logic [ADDR_W-1:0]        iter_count,
   output logic [1:0]               state,
   output logic                     halt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_CLOSE = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam int unsigned HOLD_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
   localparam logic [ADDR_W-1:0] UNITS    = ADDR_W'(NUM_UNITS);
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ITER_MAX = ADDR_W'(MAX_ITER);
   localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(DONE_HOLD - 1);

   state_t            st;
   logic [ADDR_W-1:0] depth;
   logic [ADDR_W-1:0] depth_next;
   logic [ADDR_W-1:0] depth_m1;
   logic [ADDR_W-1:0] a_last;
   logic [ADDR_W-1:0] iter_inc;
   logic [ADDR_W-1:0] rd_a [NUM_CH];
   logic [ADDR_W-1:0] wr_a [NUM_CH];
   logic [HOLD_W-1:0] hold;

   always_comb begin
      depth_next = total / UNITS;
      if ((total % UNITS) != '0)
         depth_next = depth_next + ONE;
      if (depth_next == '0)
         depth_next = ONE;
   end

   assign depth_m1 = depth - ONE;
   assign a_last   = (depth * UNITS) - ONE;
   assign iter_inc = (iter_count == '1) ? iter_count : iter_count + ONE;

   always_ff @(posedge clk) begin
      if (reset) begin
         st         <= S_IDLE;
         depth      <= ONE;
         a_rd_addr  <= '0;
         iter_count <= '0;
         rd_wrap    <= '0;
         hold       <= '0;
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            rd_a[k] <= '0;
            wr_a[k] <= '0;
         end
      end else begin
         rd_wrap <= '0;
         case (st)
            S_IDLE: begin
               if (start) begin
                  depth <= depth_next;
                  st    <= S_RUN;
               end
            end
            S_RUN: begin
               if (finish_all) begin
                  st         <= S_HALT;
                  iter_count <= iter_inc;
                  hold       <= '0;
               end else begin
                  for (int unsigned k = 0; k < NUM_CH; k++) begin
                     if (rd_adv[k]) begin
                        if (rd_a[k] == depth_m1) begin
                           rd_a[k]    <= '0;
                           rd_wrap[k] <= 1'b1;
                        end else begin
                           rd_a[k] <= rd_a[k] + ONE;
                        end
                     end
                     if (wr_req[k])
                        wr_a[k] <= (wr_a[k] == depth_m1) ? '0 : wr_a[k] + ONE;
                  end
                  if (a_stream_en)
                     a_rd_addr <= (a_rd_addr == a_last) ? '0 : a_rd_addr + ONE;
                  if (!phase_done) begin
                     hold <= '0;
                  end else if (hold == HOLD_END) begin
                     hold <= '0;
                     st   <= S_CLOSE;
                  end else begin
                     hold <= hold + HOLD_W'(1);
                  end
               end
            end
            S_CLOSE: begin
               // finish_all here counts the iteration once and keeps addresses
               iter_count <= iter_inc;
               hold       <= '0;
               if (finish_all) begin
                  st <= S_HALT;
               end else begin
                  a_rd_addr <= '0;
                  for (int unsigned k = 0; k < NUM_CH; k++) begin
                     rd_a[k] <= '0;
                     wr_a[k] <= '0;
                  end
                  st <= (iter_inc == ITER_MAX) ? S_HALT : S_RUN;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_addr = '0;
      wr_addr = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         rd_addr[k*ADDR_W +: ADDR_W] = rd_a[k];
         wr_addr[k*ADDR_W +: ADDR_W] = wr_a[k];
      end
   end

   assign wr_we = (st == S_RUN) ? wr_req : '0;
   assign state = st;
   assign halt  = (st == S_HALT);

endmodule

// File: tb/tb_cg_addr_sequencer.sv
// Directed bench for cg_addr_sequencer with default parameters
// (NUM_UNITS=8, ADDR_W=32, NUM_CH=4, MAX_ITER=3, DONE_HOLD=5).
module tb_cg_addr_sequencer;

   logic         clk = 1'b0;
   logic         reset, start, a_stream_en, phase_done, finish_all;
   logic [31:0]  total;
   logic [3:0]   rd_adv, wr_req;
   logic [31:0]  a_rd_addr, iter_count;
   logic [127:0] rd_addr, wr_addr;
   logic [3:0]   wr_we, rd_wrap;
   logic [1:0]   state;
   logic         halt;

   int n_cmp = 0;
   int n_bad = 0;

   cg_addr_sequencer #(
      .NUM_UNITS(8), .ADDR_W(32), .NUM_CH(4), .MAX_ITER(3), .DONE_HOLD(5)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .total(total),
      .a_stream_en(a_stream_en), .rd_adv(rd_adv), .wr_req(wr_req),
      .phase_done(phase_done), .finish_all(finish_all),
      .a_rd_addr(a_rd_addr), .rd_addr(rd_addr), .wr_addr(wr_addr),
      .wr_we(wr_we), .rd_wrap(rd_wrap), .iter_count(iter_count),
      .state(state), .halt(halt)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_inputs();
      start = 0; total = '0; a_stream_en = 0; rd_adv = '0; wr_req = '0;
      phase_done = 0; finish_all = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1;
      tick(2);
      reset = 0;
   endtask

   task automatic start_run(input logic [31:0] t);
      total = t; start = 1;
      tick();
      start = 0; total = '0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state); end
      n_cmp++; if (halt !== 1'b0) begin n_bad++; $display("FAIL reset_halt: got %0b expected 0", halt); end
      n_cmp++; if (iter_count !== 32'd0) begin n_bad++; $display("FAIL reset_iter: got %0d expected 0", iter_count); end
      n_cmp++; if (rd_addr !== '0 || wr_addr !== '0 || a_rd_addr !== '0) begin n_bad++;
         $display("FAIL reset_addr: rd=%0h wr=%0h a=%0h expected all 0", rd_addr, wr_addr, a_rd_addr); end
      n_cmp++; if (rd_wrap !== 4'd0) begin n_bad++; $display("FAIL reset_wrap: got %b expected 0000", rd_wrap); end
      rd_adv = 4'hF; wr_req = 4'hF; a_stream_en = 1;
      #1;
      n_cmp++; if (wr_we !== 4'd0) begin n_bad++; $display("FAIL idle_wr_we: got %b expected 0000", wr_we); end
      tick(2);
      n_cmp++; if (rd_addr !== '0 || wr_addr !== '0 || a_rd_addr !== '0) begin n_bad++;
         $display("FAIL idle_strobe_hold: rd=%0h wr=%0h a=%0h expected all 0", rd_addr, wr_addr, a_rd_addr); end
      clear_inputs();
   endtask

   task automatic test_rd_wrap();
      do_reset();
      start_run(32'd64);
      n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL run_entry: got %0d expected 1", state); end
      // start while running must not reload depth (total=0 would give depth 1)
      total = '0; start = 1;
      tick();
      start = 0;
      n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL start_in_run: got %0d expected 1", state); end
      rd_adv = 4'b0001;
      for (int i = 1; i <= 8; i++) begin
         tick();
         n_cmp++; if (rd_addr[31:0] !== 32'(i % 8)) begin n_bad++;
            $display("FAIL rd0_step%0d: got %0d expected %0d", i, rd_addr[31:0], i % 8); end
         n_cmp++; if (rd_wrap !== ((i == 8) ? 4'b0001 : 4'b0000)) begin n_bad++;
            $display("FAIL rd0_wrap_step%0d: got %b expected %b", i, rd_wrap, (i == 8) ? 4'b0001 : 4'b0000); end
      end
      rd_adv = '0;
      tick();
      n_cmp++; if (rd_wrap !== 4'b0000 || rd_addr !== '0) begin n_bad++;
         $display("FAIL rd0_after_wrap: wrap=%b rd=%0h expected 0000 / 0", rd_wrap, rd_addr); end
   endtask

   task automatic test_a_stream();
      a_stream_en = 1;
      tick(63);
      n_cmp++; if (a_rd_addr !== 32'd63) begin n_bad++; $display("FAIL a_top: got %0d expected 63", a_rd_addr); end
      tick();
      a_stream_en = 0;
      n_cmp++; if (a_rd_addr !== 32'd0) begin n_bad++; $display("FAIL a_wrap: got %0d expected 0", a_rd_addr); end
   endtask

   task automatic test_wr();
      do_reset();
      start_run(32'd60);
      wr_req = 4'b0100;
      #1;
      n_cmp++; if (wr_we !== 4'b0100) begin n_bad++; $display("FAIL run_wr_we: got %b expected 0100", wr_we); end
      tick(9);
      wr_req = '0;
      n_cmp++; if (wr_addr !== {32'd0, 32'd1, 32'd0, 32'd0}) begin n_bad++;
         $display("FAIL wr2_wrap: got %h expected ch2=1 others 0", wr_addr); end
      n_cmp++; if (rd_wrap !== 4'b0000) begin n_bad++; $display("FAIL wr_no_wrap_pulse: got %b expected 0000", rd_wrap); end
   endtask

   task automatic test_simultaneous();
      rd_adv = 4'hF; wr_req = 4'hF;
      tick(3);
      rd_adv = '0; wr_req = '0;
      n_cmp++; if (rd_addr !== {4{32'd3}}) begin n_bad++; $display("FAIL simul_rd: got %h expected all 3", rd_addr); end
      n_cmp++; if (wr_addr !== {32'd3, 32'd4, 32'd3, 32'd3}) begin n_bad++;
         $display("FAIL simul_wr: got %h expected 3,4,3,3", wr_addr); end
   endtask

   task automatic test_close();
      do_reset();
      start_run(32'd64);
      rd_adv = 4'hF; wr_req = 4'hF; a_stream_en = 1;
      tick(2);
      rd_adv = '0; wr_req = '0; a_stream_en = 0;
      phase_done = 1;
      tick(4);
      phase_done = 0;
      tick();
      n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL hold_broken: got %0d expected 1", state); end
      phase_done = 1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         n_cmp++; if (state !== ((i == 5) ? 2'd2 : 2'd1)) begin n_bad++;
            $display("FAIL hold_cycle%0d: got %0d expected %0d", i, state, (i == 5) ? 2 : 1); end
      end
      phase_done = 0;
      n_cmp++; if (iter_count !== 32'd0) begin n_bad++; $display("FAIL close_iter_pre: got %0d expected 0", iter_count); end
      tick();
      n_cmp++; if (state !== 2'd1 || iter_count !== 32'd1) begin n_bad++;
         $display("FAIL close_done: state=%0d iter=%0d expected 1 / 1", state, iter_count); end
      n_cmp++; if (rd_addr !== '0 || wr_addr !== '0 || a_rd_addr !== '0) begin n_bad++;
         $display("FAIL close_clear: rd=%0h wr=%0h a=%0h expected all 0", rd_addr, wr_addr, a_rd_addr); end
   endtask

   task automatic test_halt();
      for (int n = 2; n <= 3; n++) begin
         phase_done = 1;
         tick(5);
         phase_done = 0;
         tick();
         n_cmp++; if (iter_count !== 32'(n)) begin n_bad++;
            $display("FAIL iter_after_close%0d: got %0d expected %0d", n, iter_count, n); end
      end
      n_cmp++; if (state !== 2'd3 || halt !== 1'b1) begin n_bad++;
         $display("FAIL max_iter_halt: state=%0d halt=%0b expected 3 / 1", state, halt); end
      rd_adv = 4'hF; wr_req = 4'hF; a_stream_en = 1; start = 1; phase_done = 1;
      #1;
      n_cmp++; if (wr_we !== 4'd0) begin n_bad++; $display("FAIL halt_wr_we: got %b expected 0000", wr_we); end
      tick(6);
      n_cmp++; if (rd_addr !== '0 || wr_addr !== '0 || a_rd_addr !== '0 || state !== 2'd3 || iter_count !== 32'd3) begin
         n_bad++; $display("FAIL halt_frozen: rd=%0h wr=%0h a=%0h st=%0d it=%0d expected 0/0/0/3/3",
                           rd_addr, wr_addr, a_rd_addr, state, iter_count); end
      clear_inputs();
   endtask

   task automatic test_finish();
      do_reset();
      start_run(32'd64);
      rd_adv = 4'b0001;
      tick(2);
      rd_adv = '0;
      phase_done = 1;
      tick(4);
      finish_all = 1; rd_adv = 4'b0001;
      tick();
      clear_inputs();
      n_cmp++; if (state !== 2'd3 || iter_count !== 32'd1) begin n_bad++;
         $display("FAIL finish_halt: state=%0d iter=%0d expected 3 / 1", state, iter_count); end
      n_cmp++; if (rd_addr[31:0] !== 32'd2) begin n_bad++; $display("FAIL finish_addr_hold: got %0d expected 2", rd_addr[31:0]); end
      tick(3);
      n_cmp++; if (iter_count !== 32'd1 || halt !== 1'b1) begin n_bad++;
         $display("FAIL finish_once: iter=%0d halt=%0b expected 1 / 1", iter_count, halt); end
   endtask

   task automatic test_depth_one();
      do_reset();
      start_run(32'd0);
      rd_adv = 4'b1000;
      tick();
      rd_adv = '0;
      n_cmp++; if (rd_addr[127:96] !== 32'd0 || rd_wrap !== 4'b1000) begin n_bad++;
         $display("FAIL depth1_wrap: rd3=%0d wrap=%b expected 0 / 1000", rd_addr[127:96], rd_wrap); end
      a_stream_en = 1;
      tick(7);
      n_cmp++; if (a_rd_addr !== 32'd7) begin n_bad++; $display("FAIL depth1_a_top: got %0d expected 7", a_rd_addr); end
      tick();
      a_stream_en = 0;
      n_cmp++; if (a_rd_addr !== 32'd0) begin n_bad++; $display("FAIL depth1_a_wrap: got %0d expected 0", a_rd_addr); end
   endtask

   task automatic test_reset_midrun();
      do_reset();
      start_run(32'd64);
      rd_adv = 4'hF; wr_req = 4'hF; a_stream_en = 1;
      tick(3);
      reset = 1; start = 1;
      tick();
      n_cmp++; if (state !== 2'd0 || halt !== 1'b0 || iter_count !== 32'd0 || rd_wrap !== 4'd0) begin n_bad++;
         $display("FAIL midrun_reset_ctl: st=%0d halt=%0b it=%0d wrap=%b expected 0/0/0/0000", state, halt, iter_count, rd_wrap); end
      n_cmp++; if (rd_addr !== '0 || wr_addr !== '0 || a_rd_addr !== '0 || wr_we !== 4'd0) begin n_bad++;
         $display("FAIL midrun_reset_addr: rd=%0h wr=%0h a=%0h we=%b expected all 0", rd_addr, wr_addr, a_rd_addr, wr_we); end
      tick();
      reset = 0;
      clear_inputs();
      tick();
      n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL start_during_reset: got %0d expected 0", state); end
   endtask

   initial begin
      clear_inputs();
      reset = 1;
      test_reset();
      test_rd_wrap();
      test_a_stream();
      test_wr();
      test_simultaneous();
      test_close();
      test_halt();
      test_finish();
      test_depth_one();
      test_reset_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
